// File: rtl/line_memory_pkg.sv
// Shared constants and FSM state type for the cache backing memory and its controller.
package mem_pkg;

  localparam int unsigned LINE_W          = 256;
  localparam int unsigned OFFSET_W        = 5;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned DEFAULT_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // WAIT spends LATENCY-1 cycles counting down to zero, ACK adds the last one.
  function automatic logic [CNT_W-1:0] latency_load(input int unsigned latency);
    return CNT_W'(latency - 2);
  endfunction

endpackage

// File: rtl/line_memory_if.sv
// Request/acknowledge bus between the cache controller (master) and line memory (slave).
interface line_memory_if #(
    parameter int unsigned LINE_W = mem_pkg::LINE_W
);

    logic                     req_i;
    logic                     write_i;
    logic [mem_pkg::ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0]        data_i;
    logic                     ack_o;
    logic [LINE_W-1:0]        data_o;
    logic                     busy_o;

    modport master (
        output req_i,
        output write_i,
        output addr_i,
        output data_i,
        input  ack_o,
        input  data_o,
        input  busy_o
    );

    modport slave (
        input  req_i,
        input  write_i,
        input  addr_i,
        input  data_i,
        output ack_o,
        output data_o,
        output busy_o
    );

endinterface

// File: rtl/line_memory_array.sv
// Single-port DEPTH x LINE_W storage with registered read; no reset so it maps onto RAM.
module line_mem_array #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned DEPTH  = 512
) (
    input  logic                     clk_i,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [LINE_W-1:0]        i_wdata,
    output logic [LINE_W-1:0]        o_rdata
);

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        r_rdata <= r_mem[i_idx];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/line_memory.sv
// Fixed-latency line store answering cache refills and write-backs over a req/ack handshake.
module line_memory
    import mem_pkg::*;
#(
    parameter int unsigned LINE_W  = mem_pkg::LINE_W,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = mem_pkg::DEFAULT_LATENCY
) (
    input  logic         clk_i,
    input  logic         rst_i,
    line_memory_if.slave bus
);

    localparam int unsigned       IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LOAD = latency_load(LATENCY);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_write;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_data;
    logic              r_ack;

    logic              w_accept;
    logic              w_done;
    logic              w_busy;
    logic              w_we;
    logic [IDX_W-1:0]  w_idx_in;
    logic [IDX_W-1:0]  w_arr_idx;
    logic [LINE_W-1:0] w_rdata;
    logic              w_unused_addr;

    assign w_idx_in      = bus.addr_i[OFFSET_W +: IDX_W];
    assign w_unused_addr = ^{bus.addr_i[ADDR_W-1:OFFSET_W+IDX_W], bus.addr_i[OFFSET_W-1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.req_i) w_state_nxt = WAIT;
            WAIT:    if (r_cnt == '0) w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The array is addressed from the live bus in IDLE so that the read issued at
    // acceptance already sees the requested line; no write can intervene before ACK.
    always_comb begin
        w_accept  = 1'b0;
        w_done    = 1'b0;
        w_busy    = 1'b0;
        unique case (r_state)
            IDLE:    w_accept = bus.req_i;
            WAIT: begin
                w_busy = 1'b1;
                w_done = (r_cnt == '0);
            end
            ACK:     w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
        w_arr_idx = (r_state == IDLE) ? w_idx_in : r_idx;
        w_we      = w_done & r_write;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_ack <= w_done;
            if (w_accept) begin
                r_cnt   <= CNT_LOAD;
                r_idx   <= w_idx_in;
                r_write <= bus.write_i;
                r_wdata <= bus.data_i;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_done && !r_write) begin
                r_data <= w_rdata;
            end
        end
    end

    line_mem_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .i_we    (w_we),
        .i_idx   (w_arr_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.ack_o  = r_ack;
    assign bus.busy_o = w_busy;
    assign bus.data_o = r_data;

endmodule

// File: doc/line_memory.md
# line_memory

Backing data memory for the data cache: a 256-bit-line store that responds to the cache controller's miss refills and dirty-line write-backs. Each request is accepted through a request/acknowledge handshake and completes after a fixed, programmable latency. The block sits between the cache controller and the rest of the system and models off-chip memory timing.

## Interface

- LINE_W, 256, line width in bits; must match the cache line width.
- DEPTH, 512, number of lines; power of two, ≥ 2.
- LATENCY, 10, cycles from request acceptance to `ack_o`; valid range 2 to 255.
- clk_i  in  1  clock; all logic is posedge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  request strobe from the cache controller.
- write_i  in  1  1 = write-back line, 0 = refill read; sampled with `req_i`.
- addr_i  in  32  byte address; line index = addr_i[5+IDX_W-1:5], where IDX_W = log2(DEPTH).
- data_i  in  LINE_W  write line; sampled with `req_i`.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  LINE_W  read line; valid while `ack_o` is high for a read.
- busy_o  out  1  high from acceptance through the `ack_o` cycle.

## Operation

- FSM states:
  - IDLE: waiting for a request.
  - WAIT: counting the latency.
  - ACK: completion cycle.
- Transitions:
  - IDLE -> WAIT when req_i=1. On the same edge, capture index, write_i and data_i into request registers and load cnt=LATENCY-2. busy_o goes high.
  - WAIT: decrement cnt while cnt≠0. When cnt=0, go to ACK.
  - ACK -> IDLE unconditionally.
- Memory access happens on the WAIT->ACK edge:
  - Write: mem[idx] <= captured data.
  - Read: data_o <= mem[idx].
- ack_o is registered. It is high only in the ACK state, for exactly one cycle.
- data_o holds its last read value until the next read completes. A write completion leaves data_o unchanged.
- req_i, write_i, addr_i and data_i are sampled only in IDLE. Changes in WAIT or ACK are ignored; there is no queueing.
- If req_i is still high in the IDLE cycle after ACK, a new transaction is accepted. The controller must drop req_i on the edge that ends the ack cycle.
- Address width rules:
  - addr_i[4:0] is ignored; addresses are line-aligned.
  - Bits above 5+IDX_W-1 are ignored, so addresses alias modulo DEPTH lines.
- Write/read ordering: a read issued after a write completes returns the written line.

## Timing

- Reset values: state=IDLE, cnt=0, ack_o=0, busy_o=0, data_o=0, request registers=0.
- Memory array contents are not reset. Contents are undefined at power-up and unaffected by rst_i.
- Acceptance at edge E0 -> ack_o high during the cycle following edge E0+LATENCY-1. From the req_i-sampling edge, ack_o is therefore observed LATENCY cycles later.
- busy_o rises at E0 and falls at the edge ending the ack cycle. Total busy span is LATENCY cycles.
- Back-to-back throughput: one transaction per LATENCY+1 cycles, including the mandatory IDLE cycle.
- Reset asserted mid-transaction:
  - The transaction is aborted and no memory write occurs.
  - ack_o, busy_o and data_o clear immediately (asynchronously).
  - The FSM resumes in IDLE after rst_i deasserts.
- req_i high during reset is ignored. The first possible acceptance is the first edge with rst_i low.

## Structure

- Shared package `mem_pkg`:
  - LINE_W=256, OFFSET_W=5.
  - State enum {IDLE, WAIT, ACK} (2 bits).
  - Default LATENCY constant, shared with the cache controller's timeout assertions.
- Sub-module `line_mem_array`:
  - Single-port synchronous array, DEPTH x LINE_W.
  - Inputs: we, idx, wdata. Output: registered rdata.
  - No reset, so synthesis can infer RAM.
- The top level holds the FSM, the latency counter, the request registers and the output registers.

## Test plan

- Reset then idle: hold rst_i 3 cycles with req_i=1 -> ack_o=0, busy_o=0, data_o=0 throughout; first acceptance occurs on the first edge after release.
- Write then read: write addr 0x0000_0040 with data {8{32'hDEADBEEF}}, then read 0x0000_0040 -> ack exactly 10 cycles after each acceptance; read data_o = {8{32'hDEADBEEF}}; write ack leaves data_o unchanged.
- Aliasing and offset: write 0x0000_0020 with A, then read 0x0000_4020 (index wraps at DEPTH=512) and 0x0000_003F -> both return A.
- Inputs ignored while busy: during WAIT, toggle req_i and change addr_i/data_i/write_i -> no second ack, original transaction completes unchanged, memory holds only the original write.
- Reset mid-write: accept a write of B to line 7, assert rst_i at cycle 5 -> ack never pulses; a subsequent read of line 7 returns the prior contents, not B.
- Back-to-back with LATENCY=2: hold req_i high continuously -> ack_o pulses every 3 cycles, busy_o low for exactly one cycle between transactions.
